// File: rtl/prog_loader.sv
// Serial program loader: packs bytes into 32-bit words and writes them to imem.
// Ports: CLK/RST(sync, low), START/LEN, BYTE_IN/VLD/RDY, WE/W_Ins, CPU_RST, BUSY/DONE/ERR.
// Macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR check byte (CHK state).
module prog_loader #(
  parameter int MAXW = 1024,
  parameter int TMO  = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [10:0] LEN,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VLD,
  output logic        BYTE_RDY,
  output logic        WE,
  output logic [31:0] W_Ins,
  output logic        CPU_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, FIN} state_t;
`endif

  state_t      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] w_ins_q, w_ins_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        cpu_rst_q, cpu_rst_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        rdy;
  logic        acc;
  logic        len_ok;
  logic        go;
  logic        tmo_hit;

  always_comb begin
`ifdef PROG_LOADER_CHECKSUM_EN
    rdy = (state_q == RECV) || (state_q == CHK);
`else
    rdy = (state_q == RECV);
`endif
  end

  assign acc     = rdy && BYTE_VLD;
  assign len_ok  = (LEN != 11'd0) && (32'(LEN) <= 32'(MAXW));
  assign go      = (state_q == IDLE) && START && len_ok;
  assign tmo_hit = (tmo_q == TW'(TMO - 1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    w_ins_d   = w_ins_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    cpu_rst_d = cpu_rst_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (!len_ok) begin
            err_d = 1'b1;
          end else begin
            len_d     = LEN;
            wcnt_d    = 11'd0;
            bcnt_d    = 2'd0;
            tmo_d     = '0;
            cpu_rst_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d    = 8'd0;
`endif
            state_d   = RECV;
          end
        end
      end
      RECV: begin
        if (acc) begin
          sh_d   = {sh_q[15:0], BYTE_IN};
          bcnt_d = bcnt_q + 2'd1;
          tmo_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ BYTE_IN;
`endif
          if (bcnt_q == 2'd3) begin
            w_ins_d = {sh_q, BYTE_IN};
            state_d = WRITE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WRITE: begin
        wcnt_d = wcnt_q + 11'd1;
        tmo_d  = '0;
        if (wcnt_d < len_q) begin
          state_d = RECV;
        end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d   = FIN;
          cpu_rst_d = 1'b1;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (acc) begin
          if (BYTE_IN == csum_q) begin
            state_d   = FIN;
            cpu_rst_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`endif
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      len_q     <= 11'd0;
      wcnt_q    <= 11'd0;
      bcnt_q    <= 2'd0;
      sh_q      <= 24'd0;
      w_ins_q   <= 32'd0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      w_ins_q   <= w_ins_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // A new load drops the core hold in its own START cycle.
  assign CPU_RST  = cpu_rst_q && !go;
  assign BYTE_RDY = rdy;
  assign WE       = (state_q == WRITE);
  assign W_Ins    = w_ins_q;
  assign BUSY     = (state_q != IDLE) && (state_q != FIN);
  assign DONE     = (state_q == FIN);
  assign ERR      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table of loads plus directed corner sequences.
// Works with or without PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

  localparam int TMO_T = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] len;
  logic [7:0]  byte_in;
  logic        bvld;
  logic        brdy;
  logic        we;
  logic [31:0] wins;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  prog_loader #(.MAXW(1024), .TMO(TMO_T)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .LEN(len),
    .BYTE_IN(byte_in), .BYTE_VLD(bvld), .BYTE_RDY(brdy),
    .WE(we), .W_Ins(wins), .CPU_RST(cpu_rst),
    .BUSY(busy), .DONE(done), .ERR(err)
  );

  int nchk = 0;
  int nerr = 0;

  logic [31:0] wq[$];
  int done_n = 0;
  int err_n  = 0;
  int busy_n = 0;

  always @(negedge clk) begin
    if (we) wq.push_back(wins);
    if (done) done_n++;
    if (err) err_n++;
    if (busy) busy_n++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      byte_in = b;
      bvld = 1'b1;
      #1;
      if (brdy) begin
        @(posedge clk);
        #1;
        bvld = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      bvld = 1'b0;
      chk("byte_rdy_wait", 32'd0, 32'd1);
    end
  endtask

  task automatic do_start(input logic [10:0] l);
    @(negedge clk);
    start = 1'b1;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [10:0] len;
    logic [63:0] bytes;
    int          nb;
    int          n_we;
    logic [31:0] w0;
    logic [31:0] w1;
    int          n_done;
    int          n_err;
    logic        cpu;
  } vec_t;

  vec_t tv[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   ws, ds, es, bs, n;
    logic [7:0] x;
    logic [7:0] b;

    tv[0] = '{11'd0, 64'h0, 0, 0, 32'h0, 32'h0, 0, 1, 1'b0};
    tv[1] = '{11'd1025, 64'h0, 0, 0, 32'h0, 32'h0, 0, 1, 1'b0};
    tv[2] = '{11'd2, 64'h20080005_8C090000, 8, 2,
              32'h20080005, 32'h8C090000, 1, 0, 1'b1};
    tv[3] = '{11'd1, 64'hDEADBEEF_00000000, 4, 1,
              32'hDEADBEEF, 32'h0, 1, 0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    len = 11'd0;
    byte_in = 8'd0;
    bvld = 1'b0;
    idle(3);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wins", wins, 32'd0);
    chk("rst_rdy", {31'd0, brdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cpu", {31'd0, cpu_rst}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      ws = wq.size();
      ds = done_n;
      es = err_n;
      bs = busy_n;
      x = 8'd0;
      do_start(tv[i].len);
      for (int j = 0; j < tv[i].nb; j++) begin
        b = tv[i].bytes[63-8*j -: 8];
        x = x ^ b;
        send_byte(b);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (tv[i].nb > 0) send_byte(x);
`endif
      idle(5);
      chk($sformatf("v%0d_we_n", i), wq.size() - ws, tv[i].n_we);
      if (tv[i].n_we >= 1 && wq.size() > ws)
        chk($sformatf("v%0d_w0", i), wq[ws], tv[i].w0);
      if (tv[i].n_we >= 2 && wq.size() > ws + 1)
        chk($sformatf("v%0d_w1", i), wq[ws+1], tv[i].w1);
      chk($sformatf("v%0d_done", i), done_n - ds, tv[i].n_done);
      chk($sformatf("v%0d_err", i), err_n - es, tv[i].n_err);
      chk($sformatf("v%0d_cpu", i), {31'd0, cpu_rst}, {31'd0, tv[i].cpu});
      if (tv[i].nb == 0)
        chk($sformatf("v%0d_busy", i), busy_n - bs, 0);
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // Gap of 10 cycles mid-word; also core hold drops in START cycle.
    ws = wq.size();
    ds = done_n;
    es = err_n;
    @(negedge clk);
    start = 1'b1;
    len = 11'd1;
    #1;
    chk("cpu_rst_start", {31'd0, cpu_rst}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    idle(10);
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge clk);
    chk("gap_we_timing", {31'd0, we}, 32'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    idle(5);
    chk("gap_we_n", wq.size() - ws, 1);
    if (wq.size() > ws) chk("gap_w0", wq[ws], 32'h11223344);
    chk("gap_err", err_n - es, 0);
    chk("gap_done", done_n - ds, 1);

    // Timeout after 3 bytes.
    ws = wq.size();
    es = err_n;
    do_start(11'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (err) begin
        n = k;
        break;
      end
    end
    chk("tmo_cycles", n, TMO_T);
    idle(3);
    chk("tmo_err_n", err_n - es, 1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_we_n", wq.size() - ws, 0);
    chk("tmo_cpu", {31'd0, cpu_rst}, 32'd0);

    // Reset mid-load, then a fresh single-word load.
    do_start(11'd2);
    for (int j = 0; j < 6; j++) send_byte(8'h55);
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_rdy", {31'd0, brdy}, 32'd0);
    chk("mrst_wins", wins, 32'd0);
    chk("mrst_cpu", {31'd0, cpu_rst}, 32'd0);
    rst_n = 1'b1;
    ws = wq.size();
    ds = done_n;
    do_start(11'd1);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hBA);
    send_byte(8'hBE);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE);
`endif
    idle(5);
    chk("mrst_we_n", wq.size() - ws, 1);
    if (wq.size() > ws) chk("mrst_w0", wq[ws], 32'hCAFEBABE);
    chk("mrst_done", done_n - ds, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    ds = done_n;
    es = err_n;
    do_start(11'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h04);
    idle(4);
    chk("cs_ok_done", done_n - ds, 1);
    chk("cs_ok_err", err_n - es, 0);
    chk("cs_ok_cpu", {31'd0, cpu_rst}, 32'd1);
    ds = done_n;
    es = err_n;
    do_start(11'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    idle(4);
    chk("cs_bad_done", done_n - ds, 0);
    chk("cs_bad_err", err_n - es, 1);
    chk("cs_bad_cpu", {31'd0, cpu_rst}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAXW, default 1024, meaning the maximum word count accepted.
REQ-002 SHALL have parameter TMO, default 65535, meaning the inter-byte timeout in clock cycles.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-low reset.
REQ-005 SHALL have port START, input, 1, a level that begins a load when in IDLE.
REQ-006 SHALL have port LEN, input, 11, the word count, sampled in the START cycle.
REQ-007 SHALL have port BYTE_IN, input, 8, the serial program byte.
REQ-008 SHALL have port BYTE_VLD, input, 1, which qualifies BYTE_IN.
REQ-009 SHALL have port BYTE_RDY, output, 1; a byte is accepted when BYTE_VLD and BYTE_RDY are both high at an edge.
REQ-010 SHALL have port WE, output, 1, the instruction-memory write strobe to the fetch stage.
REQ-011 SHALL have port W_Ins, output, 32, the instruction word written when WE is high.
REQ-012 SHALL have port CPU_RST, output, 1, active-low core hold; it is 0 while the core is held.
REQ-013 SHALL have ports BUSY, DONE and ERR, output, 1 each, for status.

Function
REQ-014 SHALL implement states IDLE, RECV, WRITE, CHK and FIN.
REQ-015 IDLE with START=1 SHALL latch LEN, clear the byte and word counters, drive CPU_RST=0 and go to RECV; if LEN=0 or LEN>MAXW it SHALL pulse ERR for 1 cycle and stay in IDLE.
REQ-016 RECV SHALL drive BYTE_RDY=1 and shift accepted bytes big-endian: the first byte goes to W_Ins[31:24] and the fourth to [7:0].
REQ-017 On acceptance of the fourth byte, the FSM SHALL enter WRITE on the next edge.
REQ-018 WRITE SHALL last exactly 1 cycle with WE=1 and BYTE_RDY=0, and increment the word counter.
REQ-019 After WRITE, the FSM SHALL return to RECV if the word counter is below LEN; otherwise it SHALL go to CHK when checksum is enabled, or to FIN when it is not.
REQ-020 W_Ins SHALL hold its value outside WRITE, and WE SHALL never be high outside WRITE.
REQ-021 FIN SHALL pulse DONE for 1 cycle, set CPU_RST=1 from that cycle on, and return to IDLE.
REQ-022 BUSY SHALL be 1 in RECV, WRITE and CHK, and 0 otherwise.
REQ-023 In RECV or CHK, a timeout counter SHALL reset on each accepted byte; on reaching TMO cycles without an accepted byte, the block SHALL pulse ERR for 1 cycle, return to IDLE, and hold CPU_RST=0.
REQ-024 START SHALL be ignored when not in IDLE, and BYTE_VLD SHALL be ignored outside RECV and CHK.
REQ-025 A load following a successful load SHALL drive CPU_RST back to 0 in its START cycle.

Reset
REQ-026 RST=0 at an edge SHALL force IDLE and clear all counters, with outputs WE=0, W_Ins=0, BYTE_RDY=0, BUSY=0, DONE=0, ERR=0 and CPU_RST=0.
REQ-027 Reset mid-load SHALL abandon the partial word with no WE issued, and the next START SHALL begin a fresh load.

Configuration
REQ-028 With macro PROG_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all data bytes, and CHK SHALL accept one byte (BYTE_RDY=1).
REQ-029 If the CHK byte equals the running XOR, the FSM SHALL go to FIN; otherwise it SHALL pulse ERR, return to IDLE and hold CPU_RST=0.
REQ-030 Without the macro, CHK and the XOR logic SHALL be absent, and the last WRITE SHALL go directly to FIN.

Verification
REQ-031 LEN=2, bytes 20 08 00 05 8C 09 00 00 -> WE pulses carrying 0x20080005 then 0x8C090000, then DONE pulses and CPU_RST=1.
REQ-032 BYTE_VLD deasserted for 10 cycles between bytes 2 and 3 of a word -> W_Ins and WE timing are unchanged apart from the delay, and no ERR is raised.
REQ-033 TMO=100, LEN=1, only 3 bytes sent -> ERR pulses at idle cycle 100, the FSM is in IDLE, no WE has been issued and CPU_RST=0.
REQ-034 Checksum enabled, LEN=1, bytes 01 02 03 04 and check byte 0x04 -> DONE; the same data with check byte 0x05 -> ERR and CPU_RST=0.
REQ-035 RST=0 asserted after 6 bytes of LEN=2, then a new START with LEN=1 and 4 bytes -> exactly one WE, carrying the new word.
REQ-036 LEN=0 and LEN=MAXW+1 -> each gives a single ERR pulse, BUSY stays 0 and WE stays 0.
